sdpram_stream_fifo_ctrl: RTL and testbench

Synchronous stream FIFO controller placed directly around the team's common-clock simple-dual-port block RAM wrapper (2-cycle read latency, write_first). It accepts an upstream valid/ready stream, writes it into the RAM through port A, and issues port-B reads. It absorbs the 2-cycle RAM read latency in a 4-entry output skid buffer, so it presents a first-word-fall-through valid/ready stream downstream at full throughput. It owns all RAM address, enable and pointer logic; the RAM wrapper itself stays unmodified.

---
 rtl/sdpram_stream_fifo_ctrl.sv | 146 ++++++++++++++
 tb/tb_sdpram_stream_fifo_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdpram_stream_fifo_ctrl.sv
// sdpram_stream_fifo_ctrl
// Stream FIFO controller wrapped around a common-clock simple-dual-port RAM
// with 2-cycle read latency. Upstream words are written through port A and
// read back through port B. A 4-entry output skid buffer, fed under a read
// credit rule, hides the RAM latency and gives a first-word-fall-through
// downstream stream at full throughput.
//
// Ports
//   clka, rsta_n       clock, async active-low reset
//   s_data/valid/ready upstream stream
//   m_data/valid/ready downstream stream (head of output buffer)
//   count              words held: RAM + in-flight reads + output buffer
//   ram_*              RAM wrapper port A (write) and port B (read) controls
module sdpram_stream_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH_A       = 6,
  parameter int unsigned WRITE_DATA_WIDTH_A = 32
) (
  input  logic                          clka,
  input  logic                          rsta_n,
  input  logic [WRITE_DATA_WIDTH_A-1:0] s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [WRITE_DATA_WIDTH_A-1:0] m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [ADDR_WIDTH_A:0]         count,
  output logic [WRITE_DATA_WIDTH_A-1:0] ram_dina,
  output logic [ADDR_WIDTH_A-1:0]       ram_addra,
  output logic                          ram_wea,
  output logic                          ram_ena,
  output logic [ADDR_WIDTH_A-1:0]       ram_addrb,
  output logic                          ram_enb,
  output logic                          ram_regceb,
  output logic                          ram_rstb,
  input  logic [WRITE_DATA_WIDTH_A-1:0] ram_doutb
);

  localparam int unsigned AW    = ADDR_WIDTH_A;
  localparam int unsigned DW    = WRITE_DATA_WIDTH_A;
  localparam int unsigned CW    = ADDR_WIDTH_A + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH_A;
  localparam int unsigned OBW   = 3;   // obuf count width, 0..4 plus credit sum up to 6
  localparam int unsigned OBIW  = 2;   // obuf index width
  localparam int unsigned OBN   = 4;   // obuf entries

  logic [AW-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0]   ram_cnt_q,  ram_cnt_d;
  logic [1:0]      infl_q,     infl_d;
  logic [OBW-1:0]  obuf_cnt_q, obuf_cnt_d;
  logic [OBIW-1:0] obuf_wr_q,  obuf_wr_d;
  logic [OBIW-1:0] obuf_rd_q,  obuf_rd_d;
  logic [CW-1:0]   count_q,    count_d;
  logic [DW-1:0]   obuf_mem [OBN];

  logic wr_fire;
  logic rd_issue;
  logic credit_ok;
  logic ob_push;
  logic ob_pop;

  // Handshake and read-issue decisions from current state only
  always_comb begin
    s_ready   = rsta_n & (ram_cnt_q != CW'(DEPTH));
    wr_fire   = s_valid & s_ready;
    // Outstanding = buffered + in flight; an issue now can never overrun obuf
    credit_ok = (obuf_cnt_q + OBW'(infl_q[0]) + OBW'(infl_q[1])) < OBW'(OBN);
    rd_issue  = (ram_cnt_q != '0) & credit_ok;
    ob_push   = infl_q[1];
    m_valid   = (obuf_cnt_q != '0);
    ob_pop    = m_valid & m_ready;
  end

  // RAM port drive and stream outputs
  always_comb begin
    ram_dina   = s_data;
    ram_addra  = wr_ptr_q;
    ram_wea    = wr_fire;
    ram_ena    = wr_fire;
    ram_addrb  = rd_ptr_q;
    ram_enb    = rd_issue;
    ram_regceb = 1'b1;
    ram_rstb   = ~rsta_n;
    m_data     = obuf_mem[obuf_rd_q];
    count      = count_q;
  end

  // Next-state logic
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    infl_d     = infl_q;
    obuf_cnt_d = obuf_cnt_q;
    obuf_wr_d  = obuf_wr_q;
    obuf_rd_d  = obuf_rd_q;
    count_d    = count_q;

    if (wr_fire)  wr_ptr_d  = wr_ptr_q + AW'(1);
    if (rd_issue) rd_ptr_d  = rd_ptr_q + AW'(1);
    if (ob_push)  obuf_wr_d = obuf_wr_q + OBIW'(1);
    if (ob_pop)   obuf_rd_d = obuf_rd_q + OBIW'(1);

    ram_cnt_d  = ram_cnt_q + CW'(wr_fire) - CW'(rd_issue);
    infl_d     = {infl_q[0], rd_issue};
    obuf_cnt_d = obuf_cnt_q + OBW'(ob_push) - OBW'(ob_pop);
    count_d    = ram_cnt_d + CW'(infl_d[0]) + CW'(infl_d[1]) + CW'(obuf_cnt_d);
  end

  // Control state
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      infl_q     <= '0;
      obuf_cnt_q <= '0;
      obuf_wr_q  <= '0;
      obuf_rd_q  <= '0;
      count_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      infl_q     <= infl_d;
      obuf_cnt_q <= obuf_cnt_d;
      obuf_wr_q  <= obuf_wr_d;
      obuf_rd_q  <= obuf_rd_d;
      count_q    <= count_d;
    end
  end

  // Output buffer storage; contents are don't-care until counted valid
  always_ff @(posedge clka) begin
    if (ob_push) obuf_mem[obuf_wr_q] <= ram_doutb;
  end

  // A RAM return into a full buffer means the credit rule was broken
  always_ff @(posedge clka) begin
    if (rsta_n) begin
      assert (!(ob_push && (obuf_cnt_q == OBW'(OBN))))
        else $error("obuf overflow: RAM return into full output buffer");
    end
  end

endmodule

// File: tb/tb_sdpram_stream_fifo_ctrl.sv
// Bench for sdpram_stream_fifo_ctrl: behavioural 2-cycle SDP RAM plus a
// queue-based reference FIFO that tracks pushes/pops and expected occupancy.
module tb_sdpram_stream_fifo_ctrl;

  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clka   = 1'b0;
  logic          rsta_n = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [AW:0]   count;
  logic [DW-1:0] ram_dina;
  logic [AW-1:0] ram_addra;
  logic          ram_wea;
  logic          ram_ena;
  logic [AW-1:0] ram_addrb;
  logic          ram_enb;
  logic          ram_regceb;
  logic          ram_rstb;
  logic [DW-1:0] ram_doutb;

  sdpram_stream_fifo_ctrl #(.ADDR_WIDTH_A(AW), .WRITE_DATA_WIDTH_A(DW)) dut (
    .clka(clka), .rsta_n(rsta_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .count(count),
    .ram_dina(ram_dina), .ram_addra(ram_addra), .ram_wea(ram_wea), .ram_ena(ram_ena),
    .ram_addrb(ram_addrb), .ram_enb(ram_enb), .ram_regceb(ram_regceb),
    .ram_rstb(ram_rstb), .ram_doutb(ram_doutb)
  );

  always #5 clka = ~clka;

  // Behavioural RAM: read address sampled at enb, data out two edges later
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] st1, st2;
  always @(posedge clka) begin
    if (ram_wea && ram_ena) mem[ram_addra] <= ram_dina;
    if (ram_enb) st1 <= mem[ram_addrb];
    if (ram_regceb) st2 <= st1;
  end
  assign ram_doutb = st2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] q[$];
  int            exp_cnt = 0;
  int            pops    = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check DUT against the reference model at negedge, then
  // advance to just after the next rising edge.
  task automatic tick();
    @(negedge clka);
    if (rsta_n) begin
      chk("count", 64'(count), 64'(exp_cnt));
      if (stall_prev) begin
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_data", 64'(m_data), 64'(stall_data));
      end
      if (m_valid) chk("valid_nonempty", 64'(q.size() != 0), 64'd1);
      if (m_valid && m_ready && q.size() != 0) begin
        chk("data", 64'(m_data), 64'(q[0]));
        void'(q.pop_front());
        pops++;
        exp_cnt--;
      end
      if (s_valid && s_ready) begin
        q.push_back(s_data);
        exp_cnt++;
      end
      stall_prev = m_valid & ~m_ready;
      stall_data = m_data;
    end else begin
      stall_prev = 1'b0;
    end
    @(posedge clka);
    #1;
  endtask

  initial begin
    int accepted;
    int p0;
    bit seen;

    // Reset with upstream valid asserted
    #1 rsta_n = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    repeat (3) tick();
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ram_enb", 64'(ram_enb), 64'd0);
    chk("rst_ram_wea", 64'(ram_wea), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_ram_rstb", 64'(ram_rstb), 64'd1);
    s_valid = 1'b0;
    rsta_n  = 1'b1;
    tick();
    chk("post_rst_s_ready", 64'(s_ready), 64'd1);
    chk("post_rst_ram_rstb", 64'(ram_rstb), 64'd0);

    // Single word latency
    s_valid = 1'b1;
    s_data  = 32'hA5A5_0001;
    tick();                           // handshake in cycle t
    s_valid = 1'b0;
    chk("sw_enb_t1", 64'(ram_enb), 64'd1);
    chk("sw_cnt_t1", 64'(count), 64'd1);
    chk("sw_mv_t1", 64'(m_valid), 64'd0);
    tick();
    chk("sw_cnt_t2", 64'(count), 64'd1);
    chk("sw_mv_t2", 64'(m_valid), 64'd0);
    tick();
    chk("sw_cnt_t3", 64'(count), 64'd1);
    chk("sw_mv_t3", 64'(m_valid), 64'd0);
    tick();
    chk("sw_mv_t4", 64'(m_valid), 64'd1);
    chk("sw_data_t4", 64'(m_data), 64'hA5A5_0001);
    chk("sw_cnt_t4", 64'(count), 64'd1);
    m_ready = 1'b1;
    tick();
    chk("sw_cnt_after_pop", 64'(count), 64'd0);
    chk("sw_mv_after_pop", 64'(m_valid), 64'd0);

    // Fill under back-pressure
    m_ready  = 1'b0;
    accepted = 0;
    for (int i = 0; i < 100; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(accepted);
      if (s_ready) accepted++;
      tick();
    end
    s_valid = 1'b0;
    chk("fill_accepted", 64'(accepted), 64'(DEPTH + 4));
    chk("fill_s_ready", 64'(s_ready), 64'd0);
    chk("fill_count", 64'(count), 64'(DEPTH + 4));

    // Drain: no bubbles once the first word is visible
    m_ready = 1'b1;
    p0   = pops;
    seen = 1'b0;
    for (int i = 0; i < DEPTH + 20; i++) begin
      if (m_valid) seen = 1'b1;
      else if (seen && (pops - p0) < DEPTH + 4) chk("fill_no_bubble", 64'(m_valid), 64'd1);
      tick();
    end
    chk("fill_drained", 64'(pops - p0), 64'(DEPTH + 4));

    // Back-to-back streaming across several pointer wraps
    p0   = pops;
    seen = 1'b0;
    for (int i = 0; i < 220; i++) begin
      s_valid = (i < 200);
      s_data  = DW'(i);
      if (i < 200) chk("stream_s_ready", 64'(s_ready), 64'd1);
      chk("stream_count_le4", 64'(count <= 4), 64'd1);
      if (i == 4) chk("stream_latency", 64'(m_valid), 64'd1);
      if (m_valid) seen = 1'b1;
      else if (seen && (pops - p0) < 200) chk("stream_no_bubble", 64'(m_valid), 64'd1);
      tick();
    end
    s_valid = 1'b0;
    chk("stream_out", 64'(pops - p0), 64'd200);

    // Random valid/ready stalls
    for (int i = 0; i < 2000; i++) begin
      s_valid = 1'($urandom % 2);
      s_data  = $urandom;
      m_ready = 1'($urandom % 2);
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < DEPTH + 20; i++) begin
      if (exp_cnt == 0) break;
      tick();
    end
    tick();
    chk("rand_drain_model", 64'(exp_cnt), 64'd0);
    chk("rand_drain_count", 64'(count), 64'd0);

    // Reset mid-operation with reads in flight
    m_ready = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (count == 40) break;
      s_valid = 1'b1;
      s_data  = $urandom;
      tick();
    end
    s_valid = 1'b0;
    chk("mid_count40", 64'(count), 64'd40);
    m_ready = 1'b1;
    s_valid = 1'b1;
    repeat (2) begin
      s_data = $urandom;
      tick();
    end
    s_valid = 1'b0;
    rsta_n  = 1'b0;
    #1;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
    q.delete();
    exp_cnt = 0;
    tick();
    rsta_n  = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h0000_1234;
    tick();
    s_valid = 1'b0;
    p0 = pops;
    for (int i = 0; i < 20; i++) begin
      if (pops != p0) break;
      tick();
    end
    chk("mid_first_pop", 64'(pops - p0), 64'd1);
    repeat (4) tick();
    chk("mid_final_count", 64'(count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
